// File: rtl/mod_mul_il_prered.sv
`default_nettype none
// ============================================================================
// Module   : mod_mul_il_prered
// Function : Operand pre-reduction front-end for the interleaved modular
//            multiplier. It reduces a and b modulo m, then starts the
//            multiplier and registers its result.
// Revision : 1.0 - initial release
// ============================================================================
module mod_mul_il_prered #(
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   input  logic [NBITS-1:0] m,
   output logic [NBITS-1:0] mul_a,
   output logic [NBITS-1:0] mul_b,
   output logic [NBITS-1:0] mul_m,
   output logic             mul_start_p,
   input  logic             mul_done_p,
   input  logic [NBITS-1:0] mul_y,
   output logic [NBITS-1:0] y,
   output logic             done_p,
   output logic             err_p
);

   localparam int CNTW = $clog2(NBITS);
   localparam logic [CNTW-1:0] c_CNT_INIT = CNTW'(NBITS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REDUCE = 2'd1,
      S_START  = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NBITS-1:0]  r_a;
   logic [NBITS-1:0]  r_b;
   logic [NBITS-1:0]  r_m;
   logic [NBITS:0]    r_ra;
   logic [NBITS:0]    r_rb;
   logic [CNTW-1:0]   r_cnt;
   logic              w_accept;
   logic              w_m_zero;
   logic              w_last;
   logic [NBITS:0]    w_m_ext;
   logic [NBITS:0]    w_ta;
   logic [NBITS:0]    w_tb;
   logic [NBITS:0]    w_ra_nx;
   logic [NBITS:0]    w_rb_nx;
   logic              w_unused;

   assign in_ready    = (r_state == S_IDLE);
   assign mul_start_p = (r_state == S_START);
   assign w_accept    = in_valid && (r_state == S_IDLE);
   assign w_m_zero    = (m == '0);
   assign w_last      = (r_cnt == '0);

   // One restoring step per cycle: shift in the next operand bit, subtract m
   // if the partial remainder reached it. Remainder stays below m, so the
   // NBITS+1-bit comparison cannot overflow.
   assign w_m_ext = {1'b0, r_m};
   assign w_ta    = {r_ra[NBITS-1:0], r_a[r_cnt]};
   assign w_tb    = {r_rb[NBITS-1:0], r_b[r_cnt]};
   assign w_ra_nx = (w_ta >= w_m_ext) ? (w_ta - w_m_ext) : w_ta;
   assign w_rb_nx = (w_tb >= w_m_ext) ? (w_tb - w_m_ext) : w_tb;

   // Top remainder bit is always zero once stored; only kept for width.
   assign w_unused = r_ra[NBITS] ^ r_rb[NBITS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && !w_m_zero) w_next = S_REDUCE;
         S_REDUCE: if (w_last) w_next = S_START;
         S_START:  w_next = S_WAIT;
         S_WAIT:   if (mul_done_p) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_m    <= '0;
         r_ra   <= '0;
         r_rb   <= '0;
         r_cnt  <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         mul_m  <= '0;
         y      <= '0;
         done_p <= 1'b0;
         err_p  <= 1'b0;
      end else begin
         done_p <= 1'b0;
         err_p  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_m_zero) begin
                     err_p <= 1'b1;
                  end else begin
                     r_a   <= a;
                     r_b   <= b;
                     r_m   <= m;
                     r_ra  <= '0;
                     r_rb  <= '0;
                     r_cnt <= c_CNT_INIT;
                  end
               end
            end
            S_REDUCE: begin
               r_ra  <= w_ra_nx;
               r_rb  <= w_rb_nx;
               r_cnt <= r_cnt - CNTW'(1);
               if (w_last) begin
                  mul_a <= w_ra_nx[NBITS-1:0];
                  mul_b <= w_rb_nx[NBITS-1:0];
                  mul_m <= r_m;
               end
            end
            S_WAIT: begin
               if (mul_done_p) begin
                  y      <= mul_y;
                  done_p <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
